// File: rtl/from_fp9_pkg.sv
// Shared definitions for the FP9 return-path converter: type codes, FP9 field
// layout, exponent biases and the internal conversion-target encoding.
package from_fp9_pkg;

  localparam int MATRIX_BUS_WIDTH = 32;

  localparam logic [4:0] TYPE_FP4  = 5'd1;
  localparam logic [4:0] TYPE_FP8  = 5'd2;
  localparam logic [4:0] TYPE_FP16 = 5'd3;

  localparam logic [2:0] SUB_FP8E4M3 = 3'd0;
  localparam logic [2:0] SUB_FP8E5M2 = 3'd1;

  localparam int FP9_EXP_W = 5;
  localparam int FP9_MAN_W = 3;
  localparam int FP9_W     = 1 + FP9_EXP_W + FP9_MAN_W;

  localparam int FP9_BIAS  = 15;
  localparam int E5M2_BIAS = 15;
  localparam int E4M3_BIAS = 7;
  localparam int E2M1_BIAS = 1;

  localparam int E4M3_EXP_OFS = FP9_BIAS - E4M3_BIAS;

  typedef enum logic [2:0] {
    TGT_FP16,
    TGT_E5M2,
    TGT_E4M3,
    TGT_FP4,
    TGT_BAD
  } tgt_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HALF,
    ST_OUT
  } state_e;

  // Any code pair outside the supported set decodes to TGT_BAD.
  function automatic tgt_e decode_tgt(input logic [4:0] t, input logic [2:0] sub);
    tgt_e r;
    r = TGT_BAD;
    if (t == TYPE_FP16) begin
      r = TGT_FP16;
    end else if (t == TYPE_FP4) begin
      r = TGT_FP4;
    end else if (t == TYPE_FP8) begin
      if (sub == SUB_FP8E4M3) begin
        r = TGT_E4M3;
      end else if (sub == SUB_FP8E5M2) begin
        r = TGT_E5M2;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/from_fp9_round_cvt.sv
// Combinational FP9 (E5M3) to FP16 / E5M2 / E4M3 / E2M1 conversion with RNE
// rounding; the result sits in the low bits of res.
module fp9_round_cvt
  import from_fp9_pkg::*;
(
  input  logic [FP9_W-1:0] fp9,
  input  tgt_e             target,
  output logic [15:0]      res,
  output logic             of,
  output logic             uf,
  output logic             nv
);

  logic       s;
  logic [4:0] e;
  logic [2:0] m;
  logic       is_inf;
  logic       is_nan;
  logic [4:0] e_eff;
  logic [3:0] sig;

  assign s      = fp9[8];
  assign e      = fp9[7:3];
  assign m      = fp9[2:0];
  assign is_inf = (e == 5'd31) && (m == 3'd0);
  assign is_nan = (e == 5'd31) && (m != 3'd0);
  assign e_eff  = (e == 5'd0) ? 5'd1 : e;
  assign sig    = {e != 5'd0, m};

  // E5M2 shares the exponent bias, so rounding is a carry into {e, m[2:1]}.
  logic [6:0] e5_sum;
  assign e5_sum = {e, m[2:1]} + {6'd0, m[1] & m[0]};

  // E4M3 below min normal: significand expressed in units of 2^-9, then RNE.
  logic [4:0]  e4_sh;
  logic [11:0] e4_ext;
  logic        e4_g;
  logic        e4_st;
  logic        e4_up;
  logic [3:0]  e4_q;
  logic [4:0]  e4_exp;

  assign e4_sh  = 5'(E4M3_EXP_OFS + 1) - e_eff;
  assign e4_ext = {sig, 8'd0} >> e4_sh;
  assign e4_g   = e4_ext[7];
  assign e4_st  = |e4_ext[6:0];
  assign e4_up  = e4_g & (e4_st | e4_ext[8]);
  assign e4_q   = e4_ext[11:8] + {3'd0, e4_up};
  assign e4_exp = e - 5'(E4M3_EXP_OFS);

  // E2M1 below 1.0: units of 0.5, shift clamped since anything further is sticky only.
  logic [4:0] e2_sh;
  logic [8:0] e2_ext;
  logic       e2_inexact;
  logic       e2_up;
  logic [3:0] e2_q;
  logic       e2_up_n;
  logic [5:0] e2_n;
  logic       e2_of;

  assign e2_sh      = (e_eff <= 5'd12) ? 5'd5 : (5'd17 - e_eff);
  assign e2_ext     = {sig, 5'd0} >> e2_sh;
  assign e2_inexact = e2_ext[4] | (|e2_ext[3:0]);
  assign e2_up      = e2_ext[4] & ((|e2_ext[3:0]) | e2_ext[5]);
  assign e2_q       = e2_ext[8:5] + {3'd0, e2_up};
  assign e2_up_n    = m[1] & (m[0] | m[2]);
  assign e2_n       = {e - 5'd14, m[2]} + {5'd0, e2_up_n};
  assign e2_of      = is_inf || (e >= 5'd18) || ((e == 5'd17) && (m > 3'd4));

  logic unused_bits;
  assign unused_bits = ^{e4_exp[4], e2_q[3], e2_n[5:3]};

  always_comb begin
    res = '0;
    of  = 1'b0;
    uf  = 1'b0;
    nv  = 1'b0;
    case (target)
      TGT_FP16: begin
        res = {s, e, m, 7'd0};
      end
      TGT_E5M2: begin
        if (is_nan) begin
          res[7:0] = {s, 7'h7F};
        end else if (is_inf) begin
          res[7:0] = {s, 7'h7C};
        end else begin
          res[7:0] = {s, e5_sum};
          of       = (e5_sum[6:2] == 5'd31);
          uf       = (e5_sum[6:2] == 5'd0) && m[0];
        end
      end
      TGT_E4M3: begin
        if (is_nan) begin
          res[7:0] = {s, 7'h7F};
        end else if (is_inf || (e >= 5'd24) || ((e == 5'd23) && (m == 3'd7))) begin
          res[7:0] = {s, 7'h7E};
          of       = 1'b1;
        end else if (e >= 5'(E4M3_EXP_OFS + 1)) begin
          res[7:0] = {s, e4_exp[3:0], m};
        end else begin
          res[7:0] = {s, 3'd0, e4_q};
          uf       = !e4_q[3] && (e4_g | e4_st);
        end
      end
      TGT_FP4: begin
        if (is_nan) begin
          nv = 1'b1;
        end else if (e2_of) begin
          res[3:0] = {s, 3'b111};
          of       = 1'b1;
        end else if (e >= 5'd15) begin
          res[3:0] = {s, e2_n[2:0]};
        end else begin
          res[3:0] = {s, e2_q[2:0]};
          uf       = !e2_q[1] && e2_inexact;
        end
      end
      default: begin
        nv = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/from_fp9.sv
// FP9 return-path converter: converts one element per handshake and packs the
// result (two FP4 nibbles per byte) onto the matrix bus with valid/ready.
module from_fp9
  import from_fp9_pkg::*;
#(
  parameter int BUS_W = MATRIX_BUS_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       type_c,
  input  logic [2:0]       type_c_sub,
  input  logic [8:0]       c_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             flush_i,
  output logic [BUS_W-1:0] c_o,
  output logic             of_o,
  output logic             uf_o,
  output logic             nv_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  state_e      state;
  state_e      state_d;
  tgt_e        tgt_q;
  tgt_e        cvt_tgt;
  logic [3:0]  lo_nib;
  logic        lo_of;
  logic        lo_uf;
  logic        lo_nv;
  logic [15:0] cvt_res;
  logic        cvt_of;
  logic        cvt_uf;
  logic        cvt_nv;
  logic        accept;

  // The type is only sampled on the first element of a pack.
  assign cvt_tgt = (state == ST_IDLE) ? decode_tgt(type_c, type_c_sub) : tgt_q;
  assign accept  = in_valid_i && in_ready_o;

  fp9_round_cvt u_cvt (
    .fp9    (c_i),
    .target (cvt_tgt),
    .res    (cvt_res),
    .of     (cvt_of),
    .uf     (cvt_uf),
    .nv     (cvt_nv)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d     = state;
    in_ready_o  = 1'b1;
    out_valid_o = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_d = (cvt_tgt == TGT_FP4) ? ST_HALF : ST_OUT;
        end
      end
      ST_HALF: begin
        if (accept || flush_i) begin
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output word and flags only change on the edge that enters OUT, so they
  // hold steady under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_q  <= TGT_FP16;
      lo_nib <= 4'd0;
      lo_of  <= 1'b0;
      lo_uf  <= 1'b0;
      lo_nv  <= 1'b0;
      c_o    <= '0;
      of_o   <= 1'b0;
      uf_o   <= 1'b0;
      nv_o   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            tgt_q <= cvt_tgt;
            if (cvt_tgt == TGT_FP4) begin
              lo_nib <= cvt_res[3:0];
              lo_of  <= cvt_of;
              lo_uf  <= cvt_uf;
              lo_nv  <= cvt_nv;
            end else begin
              c_o  <= BUS_W'(cvt_res);
              of_o <= cvt_of;
              uf_o <= cvt_uf;
              nv_o <= cvt_nv;
            end
          end
        end
        ST_HALF: begin
          if (accept) begin
            c_o  <= BUS_W'({8'd0, cvt_res[3:0], lo_nib});
            of_o <= lo_of | cvt_of;
            uf_o <= lo_uf | cvt_uf;
            nv_o <= lo_nv | cvt_nv;
          end else if (flush_i) begin
            c_o  <= BUS_W'({12'd0, lo_nib});
            of_o <= lo_of;
            uf_o <= lo_uf;
            nv_o <= lo_nv;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_from_fp9.sv
// Self-checking bench for from_fp9: directed vector table, FP4 packing and
// reset/backpressure sequences, then random traffic against a value-level model.
module tb_from_fp9;
  import from_fp9_pkg::*;

  localparam int BW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    type_c;
  logic [2:0]    type_c_sub;
  logic [8:0]    c_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic          flush_i;
  logic [BW-1:0] c_o;
  logic          of_o;
  logic          uf_o;
  logic          nv_o;
  logic          out_valid_o;
  logic          out_ready_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  from_fp9 #(.BUS_W(BW)) dut (
    .clk         (clk),
    .rst         (rst),
    .type_c      (type_c),
    .type_c_sub  (type_c_sub),
    .c_i         (c_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .flush_i     (flush_i),
    .c_o         (c_o),
    .of_o        (of_o),
    .uf_o        (uf_o),
    .nv_o        (nv_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i)
  );

  // Reference model: decode to real values and pick the nearest code (ties to even).
  function automatic real pow2(input int n);
    real r = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
    else for (int i = 0; i < -n; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp9_mag(input logic [8:0] c);
    int e = int'(c[7:3]);
    int m = int'(c[2:0]);
    if (e == 0) return m * pow2(-17);
    return (8 + m) * pow2(e - 18);
  endfunction

  function automatic real fmt_mag(input int code, input int mb, input int bias);
    int e = code >> mb;
    int m = code & ((1 << mb) - 1);
    if (e == 0) return m * pow2(1 - bias - mb);
    return ((1 << mb) + m) * pow2(e - bias - mb);
  endfunction

  function automatic int nearest(input real x, input int mb, input int bias, input int maxc);
    int  best = 0;
    real bd   = x;
    for (int i = 1; i <= maxc; i++) begin
      real d = fmt_mag(i, mb, bias) - x;
      if (d < 0.0) d = -d;
      if ((d < bd) || ((d == bd) && (i % 2 == 0))) begin
        best = i;
        bd   = d;
      end
    end
    return best;
  endfunction

  // fmt: 0 FP16, 1 E5M2, 2 E4M3, 3 FP4
  function automatic void model(input logic [8:0] c, input int fmt,
                                output logic [15:0] r, output logic o, output logic u,
                                output logic n);
    logic s   = c[8];
    logic nan = (c[7:3] == 5'd31) && (c[2:0] != 3'd0);
    logic inf = (c[7:3] == 5'd31) && (c[2:0] == 3'd0);
    real  x   = fp9_mag(c);
    int   k;
    r = '0; o = 1'b0; u = 1'b0; n = 1'b0;
    case (fmt)
      0: r = {c, 7'd0};
      1: begin
        if (nan) r = {8'd0, s, 7'h7F};
        else if (inf) r = {8'd0, s, 7'h7C};
        else begin
          k = nearest(x, 2, 15, 124);
          r = {8'd0, s, 7'(k)};
          o = (k == 124);
          u = (k < 4) && (fmt_mag(k, 2, 15) != x);
        end
      end
      2: begin
        if (nan) r = {8'd0, s, 7'h7F};
        else if (inf || x > 448.0) begin
          r = {8'd0, s, 7'h7E};
          o = 1'b1;
        end else begin
          k = nearest(x, 3, 7, 126);
          r = {8'd0, s, 7'(k)};
          u = (k < 8) && (fmt_mag(k, 3, 7) != x);
        end
      end
      default: begin
        if (nan) n = 1'b1;
        else if (inf || x > 6.0) begin
          r = {12'd0, s, 3'b111};
          o = 1'b1;
        end else begin
          k = nearest(x, 1, 1, 7);
          r = {12'd0, s, 3'(k)};
          u = (k < 2) && (fmt_mag(k, 1, 1) != x);
        end
      end
    endcase
  endfunction

  function automatic logic [4:0] fmt_type(input int fmt);
    case (fmt)
      0: return TYPE_FP16;
      1, 2: return TYPE_FP8;
      default: return TYPE_FP4;
    endcase
  endfunction

  function automatic logic [2:0] fmt_sub(input int fmt);
    return (fmt == 1) ? SUB_FP8E5M2 : SUB_FP8E4M3;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [8:0] c, input logic [4:0] t, input logic [2:0] sb,
                               input logic fl);
    int n = 0;
    c_i = c; type_c = t; type_c_sub = sb; flush_i = fl; in_valid_i = 1'b1;
    while (!in_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_o) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: in_ready_o stayed %b expected 1", in_ready_o);
    end
    @(negedge clk);
    in_valid_i = 1'b0; flush_i = 1'b0; c_i = '0;
  endtask

  task automatic doFlush();
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] ec, input logic eo,
                             input logic eu, input logic en);
    int n = 0;
    while (!out_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid_o) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: out_valid_o stayed 0 expected 1", name);
    end else begin
      check(name, {c_o, of_o, uf_o, nv_o}, {BW'(ec), eo, eu, en});
      out_ready_i = 1'b1;
      @(negedge clk);
      out_ready_i = 1'b0;
    end
  endtask

  typedef struct {
    logic [8:0]  c;
    logic [4:0]  t;
    logic [2:0]  sb;
    logic [15:0] ec;
    logic        eo;
    logic        eu;
    logic        en;
  } vec_t;

  vec_t vecs[16];

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0] r1, r2, rr;
    logic        o1, u1, n1, o2, u2, n2;
    int          fmt;
    logic [8:0]  ca, cb;
    logic        fl;

    vecs[0]  = '{9'h078, TYPE_FP16, 3'd0,        16'h3C00, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{9'h1FF, TYPE_FP16, 3'd0,        16'hFF80, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{9'h079, TYPE_FP8,  SUB_FP8E5M2, 16'h003C, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{9'h07B, TYPE_FP8,  SUB_FP8E5M2, 16'h003E, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{9'h0F7, TYPE_FP8,  SUB_FP8E5M2, 16'h007C, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{9'h078, TYPE_FP8,  SUB_FP8E4M3, 16'h0038, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{9'h0F7, TYPE_FP8,  SUB_FP8E4M3, 16'h007E, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{9'h1FF, TYPE_FP8,  SUB_FP8E4M3, 16'h00FF, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{9'h030, TYPE_FP8,  SUB_FP8E4M3, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{9'h029, TYPE_FP8,  SUB_FP8E4M3, 16'h0001, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{9'h0BF, TYPE_FP8,  SUB_FP8E4M3, 16'h007E, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{9'h1F8, TYPE_FP8,  SUB_FP8E5M2, 16'h00FC, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{9'h004, TYPE_FP8,  SUB_FP8E5M2, 16'h0002, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{9'h001, TYPE_FP8,  SUB_FP8E5M2, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{9'h078, 5'd0,      3'd0,        16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{9'h078, TYPE_FP8,  3'd7,        16'h0000, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; type_c = '0; type_c_sub = '0; c_i = '0;
    in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0;
    #2;
    check("reset_state", {in_ready_o, out_valid_o, c_o, of_o, uf_o, nv_o},
          {1'b1, 1'b0, {BW{1'b0}}, 3'b000});
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].c, vecs[i].t, vecs[i].sb, 1'b0);
      if (i == 0) check("fp16_latency", {63'd0, out_valid_o}, 64'd1);
      checkOutput($sformatf("vec%0d", i), vecs[i].ec, vecs[i].eo, vecs[i].eu, vecs[i].en);
    end

    applyStimulus(9'h078, TYPE_FP4, 3'd0, 1'b0);
    check("fp4_half_no_valid", {63'd0, out_valid_o}, 64'd0);
    applyStimulus(9'h07C, TYPE_FP4, 3'd0, 1'b0);
    checkOutput("fp4_pair", 16'h0032, 1'b0, 1'b0, 1'b0);

    applyStimulus(9'h078, TYPE_FP4, 3'd0, 1'b0);
    applyStimulus(9'h07C, TYPE_FP16, 3'd0, 1'b0);
    checkOutput("fp4_type_change", 16'h0032, 1'b0, 1'b0, 1'b0);

    applyStimulus(9'h078, TYPE_FP4, 3'd0, 1'b0);
    doFlush();
    checkOutput("fp4_flush", 16'h0002, 1'b0, 1'b0, 1'b0);

    applyStimulus(9'h078, TYPE_FP4, 3'd0, 1'b0);
    applyStimulus(9'h07C, TYPE_FP4, 3'd0, 1'b1);
    checkOutput("fp4_accept_flush", 16'h0032, 1'b0, 1'b0, 1'b0);
    check("fp4_no_extra", {62'd0, out_valid_o, in_ready_o}, 64'd1);

    applyStimulus(9'h1FF, TYPE_FP4, 3'd0, 1'b0);
    applyStimulus(9'h0F7, TYPE_FP4, 3'd0, 1'b0);
    checkOutput("fp4_nan_of", 16'h0070, 1'b1, 1'b0, 1'b1);

    applyStimulus(9'h001, TYPE_FP4, 3'd0, 1'b0);
    applyStimulus(9'h078, TYPE_FP4, 3'd0, 1'b0);
    checkOutput("fp4_uf", 16'h0020, 1'b0, 1'b1, 1'b0);

    // Backpressure: output holds and a waiting element is not consumed.
    applyStimulus(9'h078, TYPE_FP16, 3'd0, 1'b0);
    c_i = 9'h07B; type_c = TYPE_FP16; in_valid_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_hold%0d", k), {out_valid_o, in_ready_o, c_o, of_o, uf_o, nv_o},
            {1'b1, 1'b0, BW'(16'h3C00), 3'b000});
      @(negedge clk);
    end
    out_ready_i = 1'b1;
    @(negedge clk);
    out_ready_i = 1'b0;
    check("bp_release", {62'd0, out_valid_o, in_ready_o}, 64'd1);
    @(negedge clk);
    in_valid_i = 1'b0;
    check("bp_next_valid", {63'd0, out_valid_o}, 64'd1);
    checkOutput("bp_next", 16'h3D80, 1'b0, 1'b0, 1'b0);

    // Reset in HALF drops the stored nibble.
    applyStimulus(9'h078, TYPE_FP4, 3'd0, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_half", {in_ready_o, out_valid_o, c_o, of_o, uf_o, nv_o},
          {1'b1, 1'b0, {BW{1'b0}}, 3'b000});
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(9'h07C, TYPE_FP4, 3'd0, 1'b0);
    doFlush();
    checkOutput("rst_half_restart", 16'h0003, 1'b0, 1'b0, 1'b0);

    // Reset in OUT drops the pending word.
    applyStimulus(9'h0F7, TYPE_FP8, SUB_FP8E4M3, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_out", {in_ready_o, out_valid_o, c_o, of_o, uf_o, nv_o},
          {1'b1, 1'b0, {BW{1'b0}}, 3'b000});
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(9'h078, TYPE_FP4, 3'd0, 1'b0);
    doFlush();
    checkOutput("rst_out_restart", 16'h0002, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      fmt = int'($urandom_range(0, 3));
      ca  = 9'($urandom);
      if (fmt < 3) begin
        model(ca, fmt, r1, o1, u1, n1);
        applyStimulus(ca, fmt_type(fmt), fmt_sub(fmt), 1'b0);
        checkOutput($sformatf("rand%0d_f%0d_%h", i, fmt, ca), r1, o1, u1, n1);
      end else begin
        cb = 9'($urandom);
        fl = ($urandom_range(0, 3) == 0);
        model(ca, 3, r1, o1, u1, n1);
        applyStimulus(ca, TYPE_FP4, 3'($urandom), 1'b0);
        if (fl) begin
          doFlush();
          rr = {12'd0, r1[3:0]};
          checkOutput($sformatf("rand%0d_fl_%h", i, ca), rr, o1, u1, n1);
        end else begin
          model(cb, 3, r2, o2, u2, n2);
          applyStimulus(cb, 5'($urandom), 3'($urandom), 1'($urandom));
          rr = {8'd0, r2[3:0], r1[3:0]};
          checkOutput($sformatf("rand%0d_pk_%h_%h", i, ca, cb), rr, o1 | o2, u1 | u2, n1 | n2);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
